// File: rtl/invd8bwp30p140hvt.sv
// Power-switch controller for a ring-oscillator virtual VDD. The gate control is
// registered, then NUM_FINGERS INVD8 switch fingers are turned on in a staggered ramp.
module invd8bwp30p140hvt #(
  parameter int NUM_FINGERS = 4,
  parameter int STAGGER     = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SEL_POWER_OFF,
  input  logic                   MEAS_STRESS,
  output logic [NUM_FINGERS-1:0] FINGER_EN,
  output logic                   OUT,
  output logic                   PWR_GOOD,
  output logic                   SEL_POWER_INT
);

  localparam int CW = $clog2(STAGGER + 1);
  localparam int IW = (NUM_FINGERS > 1) ? $clog2(NUM_FINGERS) : 1;
  localparam logic [CW-1:0] STAG_MAX = CW'(STAGGER);
  localparam logic [CW-1:0] STAG_M1  = CW'(STAGGER - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_FINGERS - 1);

  logic                   gate;
  logic [NUM_FINGERS-1:0] fingers, fingers_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [IW-1:0]          idx, idx_nxt;

  // INVD2 into AN2D2: stress mode forces the supply on.
  assign gate = SEL_POWER_OFF & ~MEAS_STRESS;

  always_comb begin
    fingers_nxt = fingers;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    if (SEL_POWER_INT) begin
      fingers_nxt = '0;
      cnt_nxt     = '0;
      idx_nxt     = '0;
    end else if (fingers == '0) begin
      fingers_nxt    = '0;
      fingers_nxt[0] = 1'b1;
      cnt_nxt        = '0;
      idx_nxt        = '0;
    end else if (idx != LAST_IDX) begin
      if (cnt == STAG_M1) begin
        idx_nxt              = idx + 1'b1;
        fingers_nxt[idx_nxt] = 1'b1;
        cnt_nxt              = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end else if (cnt != STAG_MAX) begin
      // Ramp complete: counter saturates rather than wrapping.
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SEL_POWER_INT <= 1'b1;
      fingers       <= '0;
      cnt           <= '0;
      idx           <= '0;
      OUT           <= 1'b0;
      PWR_GOOD      <= 1'b0;
    end else begin
      SEL_POWER_INT <= gate;
      fingers       <= fingers_nxt;
      cnt           <= cnt_nxt;
      idx           <= idx_nxt;
      OUT           <= |fingers_nxt;
      PWR_GOOD      <= &fingers_nxt;
    end
  end

  assign FINGER_EN = fingers;

endmodule

// File: tb/tb_invd8bwp30p140hvt.sv
// Bench for the power-switch controller: directed ramp/abort/reset steps, then
// random control traffic checked against a cycle-count model of the ramp.
module tb_invd8bwp30p140hvt;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SEL_POWER_OFF;
  logic       MEAS_STRESS;
  logic [3:0] fe1, fe3;
  logic       out1, pg1, si1, out3, pg3, si3;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: k = consecutive edges that sampled an on request; mdl_sel = registered gate.
  int   k       = 0;
  logic mdl_sel = 1'b1;

  always #5 CLK = ~CLK;

  invd8bwp30p140hvt #(.NUM_FINGERS(4), .STAGGER(1)) dut1 (
    .CLK(CLK), .RST(RST), .SEL_POWER_OFF(SEL_POWER_OFF), .MEAS_STRESS(MEAS_STRESS),
    .FINGER_EN(fe1), .OUT(out1), .PWR_GOOD(pg1), .SEL_POWER_INT(si1));

  invd8bwp30p140hvt #(.NUM_FINGERS(4), .STAGGER(3)) dut3 (
    .CLK(CLK), .RST(RST), .SEL_POWER_OFF(SEL_POWER_OFF), .MEAS_STRESS(MEAS_STRESS),
    .FINGER_EN(fe3), .OUT(out3), .PWR_GOOD(pg3), .SEL_POWER_INT(si3));

  function automatic logic [3:0] exp_fe(input int kk, input int stag);
    int n;
    if (kk == 0) n = 0;
    else begin
      n = 1 + (kk - 1) / stag;
      if (n > 4) n = 4;
    end
    return 4'((1 << n) - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    logic [3:0] e1, e3;
    e1 = exp_fe(k, 1);
    e3 = exp_fe(k, 3);
    chk("fe_s1",  32'(fe1),  32'(e1));
    chk("out_s1", 32'(out1), 32'(e1 != 4'd0));
    chk("pg_s1",  32'(pg1),  32'(e1 == 4'hF));
    chk("si_s1",  32'(si1),  32'(mdl_sel));
    chk("fe_s3",  32'(fe3),  32'(e3));
    chk("out_s3", 32'(out3), 32'(e3 != 4'd0));
    chk("pg_s3",  32'(pg3),  32'(e3 == 4'hF));
    chk("si_s3",  32'(si3),  32'(mdl_sel));
  endtask

  // Advance one edge, update the model from sampled values, check 1ns later.
  task automatic step();
    @(posedge CLK);
    if (!RST) begin
      if (mdl_sel) k = 0;
      else if (k < 1000) k++;
      mdl_sel = SEL_POWER_OFF & ~MEAS_STRESS;
    end
    #1;
    check_all();
  endtask

  task automatic async_reset_pulse();
    #2 RST = 1'b1;
    #1;
    k = 0;
    mdl_sel = 1'b1;
    check_all();
    chk("rst_fe", 32'(fe1), 32'h0);
    chk("rst_si", 32'(si1), 32'h1);
    #1 RST = 1'b0;
  endtask

  initial begin
    int t0;
    logic final_off;
    RST = 1'b1;
    SEL_POWER_OFF = 1'b0;
    MEAS_STRESS = 1'b0;
    #2;
    check_all();
    chk("reset_si", 32'(si1), 32'h1);
    chk("reset_out", 32'(out1), 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Default ramp.
    step();
    chk("ramp_si0", 32'(si1), 32'h0);
    chk("ramp_fe_pre", 32'(fe1), 32'h0);
    step(); chk("ramp_fe1", 32'(fe1), 32'h1); chk("ramp_out", 32'(out1), 32'h1);
    chk("ramp3_fe1", 32'(fe3), 32'h1);
    t0 = 0;
    step(); chk("ramp_fe3", 32'(fe1), 32'h3); t0++;
    step(); chk("ramp_fe7", 32'(fe1), 32'h7); t0++;
    step(); chk("ramp_feF", 32'(fe1), 32'hF); chk("ramp_pg", 32'(pg1), 32'h1); t0++;
    // Stagger of 3: count edges from 0001 until 1111 on the slow instance.
    for (int i = 0; i < 20 && fe3 != 4'hF; i++) begin
      step();
      t0++;
    end
    chk("stag3_cycles", 32'(t0), 32'd9);
    step(); chk("hold_feF", 32'(fe1), 32'hF);

    // Power down.
    SEL_POWER_OFF = 1'b1;
    step(); chk("off_si", 32'(si1), 32'h1); chk("off_fe_hold", 32'(fe1), 32'hF);
    step(); chk("off_fe", 32'(fe1), 32'h0); chk("off_pg", 32'(pg1), 32'h0);

    // Stress override keeps the supply on.
    MEAS_STRESS = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("stress_si", 32'(si1), 32'h0);
    end
    chk("stress_feF", 32'(fe1), 32'hF);

    // Abort mid-ramp, then restart from finger 0.
    MEAS_STRESS = 1'b0;
    step(); step();
    SEL_POWER_OFF = 1'b0;
    step(); step(); chk("abort_fe1", 32'(fe1), 32'h1);
    SEL_POWER_OFF = 1'b1;
    step(); chk("abort_fe3", 32'(fe1), 32'h3); chk("abort_si", 32'(si1), 32'h1);
    SEL_POWER_OFF = 1'b0;
    step(); chk("abort_fe0", 32'(fe1), 32'h0);
    step(); chk("restart_fe1", 32'(fe1), 32'h1);

    // Async reset mid-ramp at 0111.
    step(); step(); chk("pre_rst_fe7", 32'(fe1), 32'h7);
    async_reset_pulse();
    step(); chk("post_rst_si", 32'(si1), 32'h0);
    step(); chk("post_rst_fe1", 32'(fe1), 32'h1);

    // Random traffic with sub-cycle glitches and occasional async resets.
    for (int i = 0; i < 400; i++) begin
      final_off = ($urandom_range(0, 3) == 0);
      MEAS_STRESS = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0) begin
        SEL_POWER_OFF = ~final_off;
        #2;
      end
      SEL_POWER_OFF = final_off;
      if ($urandom_range(0, 49) == 0) async_reset_pulse();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/invd8bwp30p140hvt.md
INVD8BWP30P140HVT -- requirements
Module: invd8bwp30p140hvt

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The clock and reset SHALL be named CLK and RST, and SHALL be listed first among the ports.
REQ-003 Parameter NUM_FINGERS, default 4: number of INVD8 power-switch fingers driving the virtual VDD.
REQ-004 Parameter STAGGER, default 1: clock cycles between successive finger turn-ons; legal range 1-15.
REQ-005 CLK  input  1: rising-edge clock.
REQ-006 RST  input  1: asynchronous, active-high reset.
REQ-007 SEL_POWER_OFF  input  1: request to power down the ring-oscillator supply.
REQ-008 MEAS_STRESS  input  1: measure/stress mode; when high it overrides SEL_POWER_OFF and keeps the supply on.
REQ-009 FINGER_EN  output  NUM_FINGERS: per-finger switch enable; 1 = finger conducting.
REQ-010 OUT  output  1: modified VDD enable; 1 when any finger conducts.
REQ-011 PWR_GOOD  output  1: high when all fingers conduct.
REQ-012 SEL_POWER_INT  output  1: registered gate control, exposed for debug.

Function
REQ-013 The combinational gate term SHALL be g = SEL_POWER_OFF AND (NOT MEAS_STRESS), i.e. the INVD2 feeding the AN2D2.
REQ-014 SEL_POWER_INT SHALL be g registered on each rising CLK edge, giving 1 cycle of latency from the inputs.
REQ-015 Power-on request: the supply is requested on when SEL_POWER_INT = 0.
REQ-016 Power-off request: the supply is requested off when SEL_POWER_INT = 1.
REQ-017 Turn-on ramp: fingers SHALL enable in index order from 0 upward, one finger every STAGGER cycles.
REQ-018 Ramp start: finger 0 SHALL enable on the first edge at which SEL_POWER_INT is sampled 0 while all fingers are off.
REQ-019 Turn-off: all FINGER_EN bits SHALL clear together on the first edge at which SEL_POWER_INT is sampled 1.
REQ-020 Turn-off SHALL also clear the ramp counter.
REQ-021 Off request mid-ramp: all fingers SHALL clear on the next edge; no further finger enables.
REQ-022 On request after a mid-ramp abort: the ramp SHALL restart from finger 0.
REQ-023 A finger, once enabled, SHALL stay enabled until turn-off or reset; enabled fingers are never partially dropped.
REQ-024 OUT SHALL be the OR of FINGER_EN, so it is a registered output with no glitches.
REQ-025 PWR_GOOD SHALL be the AND of FINGER_EN, registered together with the final finger enable.
REQ-026 Ramp counter: width = ceil(log2(STAGGER+1)); it SHALL saturate and SHALL NOT wrap.
REQ-027 The finger index SHALL saturate at NUM_FINGERS-1.
REQ-028 A steady on request after a full ramp SHALL hold all outputs constant.
REQ-029 Input changes lasting less than one cycle between edges SHALL have no effect; only sampled values matter.

Reset
REQ-030 While RST = 1: FINGER_EN = 0, OUT = 0, PWR_GOOD = 0, SEL_POWER_INT = 1 (supply off), ramp counter = 0.
REQ-031 These reset values SHALL apply immediately, independent of CLK.
REQ-032 After RST deasserts, the first edge SHALL sample g.
REQ-033 If the sampled g = 0, the ramp SHALL begin as in REQ-018.
REQ-034 An RST assertion mid-ramp SHALL drop all fingers asynchronously.
REQ-035 After a mid-ramp reset, the ramp SHALL restart from finger 0.

Verification
REQ-036 Default ramp: defaults; RST released; SEL_POWER_OFF=0, MEAS_STRESS=0 -> SEL_POWER_INT=0 after 1 edge; FINGER_EN 0001, 0011, 0111, 1111 on 4 consecutive edges; OUT=1 from first; PWR_GOOD=1 with 1111.
REQ-037 Power down: after full ramp, SEL_POWER_OFF=1, MEAS_STRESS=0 -> SEL_POWER_INT=1 after 1 edge; FINGER_EN=0000, OUT=0, PWR_GOOD=0 on the next edge.
REQ-038 Stress override: SEL_POWER_OFF=1, MEAS_STRESS=1 -> g=0; full ramp to 1111; SEL_POWER_INT stays 0.
REQ-039 Abort mid-ramp: request off at FINGER_EN=0011 -> 0000 next edge; re-request on -> 0001 first, not 0111.
REQ-040 STAGGER=3: fingers advance every 3 cycles; 1111 is reached 9 cycles after 0001.
REQ-041 Async reset: assert RST between edges at FINGER_EN=0111 -> all outputs reach reset values before the next edge; deassert with on request -> ramp from 0001.
